// File: rtl/eth_frame_writer_pkg.sv
// Shared types and Ethernet header widths for the frame writer.
package eth_frame_writer_pkg;

    localparam int unsigned MAC_W  = 48;
    localparam int unsigned TYPE_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData,
        StDone
    } state_e;

endpackage

// File: rtl/eth_skid_buf.sv
// Two-entry FIFO of payload beats that absorbs the one-cycle source read latency.
module eth_skid_buf #(
    parameter int unsigned Width = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            if (wr_ptr_q) mem1_d = push_data_i;
            else          mem0_d = push_data_i;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = rd_ptr_q ? mem1_q : mem0_q;
    assign count_o = count_q;

endmodule

// File: rtl/eth_frame_writer.sv
// Emits an Ethernet header followed by a payload streamed from a 1-cycle-latency memory.
module eth_frame_writer
    import eth_frame_writer_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [MAC_W-1:0]      dest_mac_i,
    input  logic [MAC_W-1:0]      src_mac_i,
    input  logic [TYPE_W-1:0]     eth_type_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_W-1:0]     mem_raddr_o,
    output logic                  mem_ren_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  hdr_valid_o,
    input  logic                  hdr_ready_i,
    output logic [MAC_W-1:0]      hdr_dest_mac_o,
    output logic [MAC_W-1:0]      hdr_src_mac_o,
    output logic [TYPE_W-1:0]     hdr_type_o,
    output logic [DATA_W-1:0]     tdata_o,
    output logic [DATA_W/8-1:0]   tkeep_o,
    output logic                  tlast_o,
    output logic                  tuser_o,
    output logic                  tvalid_o,
    input  logic                  tready_i
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned BUF_W  = DATA_W + KEEP_W + 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rd_left_q, rd_left_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [KEEP_W-1:0]   last_keep_q, last_keep_d;
    logic [MAC_W-1:0]    dest_q, dest_d, src_q, src_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic                ren_q, pend_last_q;
    logic [KEEP_W-1:0]   pend_keep_q;

    logic [LEN_W-1:0]    rem, beats_calc;
    logic [KEEP_W-1:0]   keep_calc, issue_keep;
    logic                in_frame, tvalid, pop, issue, issue_last;
    logic [2:0]          level;
    logic                buf_valid, buf_last;
    logic [1:0]          buf_count;
    logic [BUF_W-1:0]    buf_data;

    eth_skid_buf #(
        .Width(BUF_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ren_q),
        .push_data_i ({mem_rdata_i, pend_keep_q, pend_last_q}),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .data_o      (buf_data),
        .count_o     (buf_count)
    );

    assign in_frame = (state_q == StHdr) || (state_q == StData);
    assign tvalid   = buf_valid && (state_q == StData);
    assign pop      = tvalid && tready_i;
    // Entries held after this cycle, counting the read already in flight; a new read
    // is only issued if its data is certain to find a free slot next cycle.
    assign level      = {1'b0, buf_count} + {2'b0, ren_q} - {2'b0, pop};
    assign issue      = in_frame && (rd_left_q != '0) && (level < 3'd2);
    assign issue_last = (rd_left_q == LEN_W'(1));
    assign issue_keep = issue_last ? last_keep_q : '1;

    always_comb begin
        state_d     = state_q;
        rd_left_d   = rd_left_q;
        raddr_d     = raddr_q;
        last_keep_d = last_keep_q;
        dest_d      = dest_q;
        src_d       = src_q;
        type_d      = type_q;

        rem        = len_i % LEN_W'(KEEP_W);
        beats_calc = LEN_W'(len_i / LEN_W'(KEEP_W)) + LEN_W'(rem != '0);
        keep_calc  = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep_calc[i] = (rem == '0) || (LEN_W'(i) < rem);
        end

        if (issue) begin
            rd_left_d = rd_left_q - LEN_W'(1);
            raddr_d   = raddr_q + ADDR_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && (len_i != '0)) begin
                    state_d     = StHdr;
                    rd_left_d   = beats_calc;
                    raddr_d     = base_addr_i;
                    last_keep_d = keep_calc;
                    dest_d      = dest_mac_i;
                    src_d       = src_mac_i;
                    type_d      = eth_type_i;
                end
            end
            StHdr:   if (hdr_ready_i) state_d = StData;
            StData:  if (pop && buf_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rd_left_q   <= '0;
            raddr_q     <= '0;
            last_keep_q <= '0;
            dest_q      <= '0;
            src_q       <= '0;
            type_q      <= '0;
            ren_q       <= 1'b0;
            pend_keep_q <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_left_q   <= rd_left_d;
            raddr_q     <= raddr_d;
            last_keep_q <= last_keep_d;
            dest_q      <= dest_d;
            src_q       <= src_d;
            type_q      <= type_d;
            ren_q       <= issue;
            pend_keep_q <= issue_keep;
            pend_last_q <= issue_last;
        end
    end

    assign {tdata_o, tkeep_o, buf_last} = buf_data;

    assign busy_o         = in_frame;
    assign done_o         = (state_q == StDone);
    assign mem_raddr_o    = raddr_q;
    assign mem_ren_o      = issue;
    assign hdr_valid_o    = (state_q == StHdr);
    assign hdr_dest_mac_o = dest_q;
    assign hdr_src_mac_o  = src_q;
    assign hdr_type_o     = type_q;
    assign tlast_o        = tvalid && buf_last;
    assign tuser_o        = 1'b0;
    assign tvalid_o       = tvalid;

endmodule

// File: doc/eth_frame_writer.md
ETH_FRAME_WRITER -- requirements
Module: eth_frame_writer

Interface
REQ-001 Parameter DATA_W, default 8, payload beat width in bits; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter ADDR_W, default 8, source memory word-address width.
REQ-003 Parameter LEN_W, default 16, frame payload length width in bytes.
REQ-004 Ports, in order:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to send a frame
len  in  LEN_W  payload length in bytes, sampled with start
base_addr  in  ADDR_W  first source word address, sampled with start
dest_mac / src_mac  in  48 each  header fields, sampled with start
eth_type  in  16  header field, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last payload beat is accepted
mem_raddr  out  ADDR_W  source read address
mem_ren  out  1  source read enable; data appears on mem_rdata exactly 1 cycle later
mem_rdata  in  DATA_W  source read data
hdr_valid  out  1  header valid
hdr_ready  in  1  header accepted when hdr_valid and hdr_ready
hdr_dest_mac / hdr_src_mac  out  48 each  registered header fields
hdr_type  out  16  registered header field
tdata  out  DATA_W  payload data
tkeep  out  DATA_W/8  byte enables
tlast  out  1  final beat of frame
tuser  out  1  error marker, always 0
tvalid  out  1  payload valid
tready  in  1  beat accepted when tvalid and tready

Function
REQ-005 FSM states: IDLE, HDR, DATA, DONE.
REQ-006 IDLE: start with len != 0 SHALL latch all inputs sampled with start and go to HDR next cycle; start with len == 0 SHALL be ignored.
REQ-007 start while busy is high SHALL be ignored; the in-flight frame is unaffected.
REQ-008 HDR: hdr_valid SHALL be 1 with latched fields stable until hdr_ready; on acceptance go to DATA.
REQ-009 Payload prefetch MAY begin in HDR; no beat SHALL be presented on tvalid before the header is accepted.
REQ-010 Beat count N = ceil(len / (DATA_W/8)); exactly N beats SHALL be issued, reading addresses base_addr .. base_addr+N-1, wrapping modulo 2^ADDR_W.
REQ-011 tkeep SHALL be all ones on every beat except the last, where it SHALL have the low (len mod (DATA_W/8)) bits set, or all ones if that remainder is 0.
REQ-012 tlast SHALL be 1 only on beat N; tdata, tkeep, tlast SHALL hold while tvalid and not tready.
REQ-013 With tready held high, throughput SHALL be one beat per cycle after the first beat; first tvalid no later than 2 cycles after header acceptance.
REQ-014 mem_ren SHALL be issued only when buffer space is guaranteed; no read data SHALL be dropped or duplicated under any tready pattern.
REQ-015 DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE; a start in the DONE cycle SHALL be ignored.
REQ-016 busy SHALL be 1 in HDR and DATA; tuser SHALL be constant 0.

Reset
REQ-017 On rst: state IDLE; busy, done, hdr_valid, tvalid, tlast, mem_ren = 0; tkeep, tdata, mem_raddr, header outputs = 0; buffer empty.
REQ-018 rst asserted mid-frame SHALL abort at once; no further beats or done pulse for that frame.

Structure
REQ-019 Shared package holds the FSM state enumeration and the Ethernet header width constants (MAC_W = 48, TYPE_W = 16).
REQ-020 One sub-module: eth_skid_buf, 2-entry buffer of {tdata, tkeep, tlast} absorbing the 1-cycle memory latency under backpressure.
REQ-021 Estimated size 200-300 lines total.

Verification
REQ-022 DATA_W=8, len=4, base_addr=0x10, tready=1, hdr_ready=1 -> 4 beats of mem[0x10..0x13], tlast on beat 4, done 1 cycle later.
REQ-023 DATA_W=32, len=6 -> 2 beats, tkeep 4'b1111 then 4'b0011, tlast on beat 2.
REQ-024 len=8, DATA_W=8, tready toggling 1,0,0,1,... -> all 8 bytes in order, data stable while stalled, no loss or duplication.
REQ-025 hdr_ready held 0 for 5 cycles -> hdr_valid stable, tvalid stays 0, then frame proceeds normally.
REQ-026 base_addr=0xFE, len=3, DATA_W=8 -> reads 0xFE, 0xFF, 0x00; start during busy and len=0 start both ignored.
REQ-027 rst pulsed after beat 2 of a 6-beat frame -> all outputs at reset values next cycle, no done; a new start then completes normally.
